// File: rtl/fuel_dispense_ctrl.sv
// Fuel dispense controller: latches grade price on nozzle lift, runs the pump,
// accumulates cost per flow pulse with a display-limit ceiling, then hands the
// final cost to the display FSM with a one-cycle start pulse.
// Optional feature macro: FUEL_PREPAY_LIMIT_EN (adds preset_limit input).
module fuel_dispense_ctrl #(
    parameter int unsigned PRICE0   = 3,
    parameter int unsigned PRICE1   = 4,
    parameter int unsigned PRICE2   = 5,
    parameter int unsigned MAX_COST = 99
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] grade,
    input  logic       nozzle_lift,
    input  logic       flow_pulse,
    input  logic       disp_done,
`ifdef FUEL_PREPAY_LIMIT_EN
    input  logic [7:0] preset_limit,
`endif
    output logic       pump_on,
    output logic       busy,
    output logic       start,
    output logic [7:0] final_cost,
    output logic [7:0] volume
);

    localparam logic [7:0] Price0    = 8'(PRICE0);
    localparam logic [7:0] Price1    = 8'(PRICE1);
    localparam logic [7:0] Price2    = 8'(PRICE2);
    localparam logic [8:0] MaxCost9  = 9'(MAX_COST);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StFueling  = 2'd1,
        StReport   = 2'd2,
        StWaitDone = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic       nozzle_q, flow_q;
    logic [7:0] price_q, price_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] final_cost_q, final_cost_d;
    logic [7:0] volume_q, volume_d;
    logic       pump_on_q, pump_on_d;
    logic       busy_q, busy_d;
    logic       start_q, start_d;

    logic       lift_rise, lift_fall, flow_rise;
    logic [7:0] price_sel;
    logic [8:0] sum9;
    logic [8:0] limit_eff;
    logic       limit_hit;

    assign lift_rise = nozzle_lift & ~nozzle_q;
    assign lift_fall = ~nozzle_lift & nozzle_q;
    assign flow_rise = flow_pulse & ~flow_q;

`ifdef FUEL_PREPAY_LIMIT_EN
    logic [7:0] preset_q, preset_d;

    // A zero or out-of-range preset falls back to the display ceiling.
    always_comb begin
        limit_eff = MaxCost9;
        if ((preset_q != 8'd0) && ({1'b0, preset_q} < MaxCost9)) begin
            limit_eff = {1'b0, preset_q};
        end
    end
`else
    assign limit_eff = MaxCost9;
`endif

    // Checked against the current accumulator so the sale stops before overflow.
    assign sum9      = {1'b0, acc_q} + {1'b0, price_q};
    assign limit_hit = (sum9 > limit_eff);

    // Grade-to-price lookup; grade 3 is rejected before this is used.
    always_comb begin
        unique case (grade)
            2'd0:    price_sel = Price0;
            2'd1:    price_sel = Price1;
            default: price_sel = Price2;
        endcase
    end

    // Sale FSM next-state, datapath updates and registered-output next values.
    always_comb begin
        state_d      = state_q;
        price_d      = price_q;
        acc_d        = acc_q;
        final_cost_d = final_cost_q;
        volume_d     = volume_q;
`ifdef FUEL_PREPAY_LIMIT_EN
        preset_d     = preset_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (lift_rise && (grade != 2'd3)) begin
                    state_d      = StFueling;
                    price_d      = price_sel;
                    acc_d        = 8'd0;
                    final_cost_d = 8'd0;
                    volume_d     = 8'd0;
`ifdef FUEL_PREPAY_LIMIT_EN
                    preset_d     = preset_limit;
`endif
                end
            end
            StFueling: begin
                if (flow_rise && !limit_hit) begin
                    acc_d = sum9[7:0];
                    if (volume_q != 8'hFF) begin
                        volume_d = volume_q + 8'd1;
                    end
                end
                // A pulse in the same cycle as the nozzle drop is still billed.
                if (lift_fall || limit_hit) begin
                    state_d      = StReport;
                    final_cost_d = acc_d;
                end
            end
            StReport: begin
                state_d = StWaitDone;
            end
            StWaitDone: begin
                if (disp_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        pump_on_d = (state_d == StFueling);
        busy_d    = (state_d != StIdle);
        start_d   = (state_d == StReport);
    end

    // State, edge-detect copies, datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            nozzle_q     <= 1'b0;
            flow_q       <= 1'b0;
            price_q      <= 8'd0;
            acc_q        <= 8'd0;
            final_cost_q <= 8'd0;
            volume_q     <= 8'd0;
            pump_on_q    <= 1'b0;
            busy_q       <= 1'b0;
            start_q      <= 1'b0;
`ifdef FUEL_PREPAY_LIMIT_EN
            preset_q     <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            nozzle_q     <= nozzle_lift;
            flow_q       <= flow_pulse;
            price_q      <= price_d;
            acc_q        <= acc_d;
            final_cost_q <= final_cost_d;
            volume_q     <= volume_d;
            pump_on_q    <= pump_on_d;
            busy_q       <= busy_d;
            start_q      <= start_d;
`ifdef FUEL_PREPAY_LIMIT_EN
            preset_q     <= preset_d;
`endif
        end
    end

    assign pump_on    = pump_on_q;
    assign busy       = busy_q;
    assign start      = start_q;
    assign final_cost = final_cost_q;
    assign volume     = volume_q;

endmodule

// File: tb/tb_fuel_dispense_ctrl.sv
// Testbench for fuel_dispense_ctrl: transaction-level sale model plus per-cycle
// output comparison and literal per-scenario expectations.
module tb_fuel_dispense_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] grade;
    logic       nozzle_lift;
    logic       flow_pulse;
    logic       disp_done;
    logic       pump_on;
    logic       busy;
    logic       start;
    logic [7:0] final_cost;
    logic [7:0] volume;
`ifdef FUEL_PREPAY_LIMIT_EN
    logic [7:0] preset_limit;
`endif

    fuel_dispense_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .grade       (grade),
        .nozzle_lift (nozzle_lift),
        .flow_pulse  (flow_pulse),
        .disp_done   (disp_done),
`ifdef FUEL_PREPAY_LIMIT_EN
        .preset_limit(preset_limit),
`endif
        .pump_on     (pump_on),
        .busy        (busy),
        .start       (start),
        .final_cost  (final_cost),
        .volume      (volume)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [15:0] sale_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Sale model: phase 0 idle, 1 fuelling, 2 report, 3 waiting for display.
    // Cost is always accepted_pulses * price; a pulse is accepted only while
    // one more unit would still fit under the limit.
    int   m_phase, m_count, m_price, m_final, m_lim;
    logic m_noz, m_flow;

    always @(posedge clk or negedge reset_n) begin
        int  n;
        bit  lr, lf, fr, hit;
        if (!reset_n) begin
            m_phase <= 0; m_count <= 0; m_price <= 0; m_final <= 0; m_lim <= 99;
            m_noz   <= 1'b0; m_flow <= 1'b0;
        end else begin
            lr = nozzle_lift && !m_noz;
            lf = !nozzle_lift && m_noz;
            fr = flow_pulse && !m_flow;
            m_noz  <= nozzle_lift;
            m_flow <= flow_pulse;
            case (m_phase)
                0: if (lr && grade != 2'd3) begin
                    m_phase <= 1;
                    m_price <= 3 + int'(grade);
                    m_count <= 0;
                    m_final <= 0;
`ifdef FUEL_PREPAY_LIMIT_EN
                    m_lim   <= (preset_limit > 0 && preset_limit < 99) ? int'(preset_limit) : 99;
`else
                    m_lim   <= 99;
`endif
                end
                1: begin
                    hit = (m_count + 1) * m_price > m_lim;
                    n   = m_count + ((fr && !hit) ? 1 : 0);
                    m_count <= n;
                    if (lf || hit) begin
                        m_phase <= 2;
                        m_final <= n * m_price;
                    end
                end
                2: m_phase <= 3;
                default: if (disp_done) m_phase <= 0;
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("pump_on", pump_on, 32'(m_phase == 1));
        check("busy", busy, 32'(m_phase != 0));
        check("start", start, 32'(m_phase == 2));
        check("final_cost", final_cost, m_final);
        check("volume", volume, (m_count > 255) ? 255 : m_count);
        if (start === 1'b1) begin
            sale_q.push_back({final_cost, volume});
            check("pump_in_report", pump_on, 0);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic lift(input logic [1:0] g);
        grade = g; nozzle_lift = 1'b1; tick();
    endtask

    task automatic drop();
        nozzle_lift = 1'b0; tick();
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            flow_pulse = 1'b1; tick();
            flow_pulse = 1'b0; tick();
        end
    endtask

    task automatic done();
        disp_done = 1'b1; tick();
        disp_done = 1'b0; tick();
    endtask

    task automatic expect_sale(input string name, input int cost, input int vol);
        int n = 0;
        logic [15:0] s;
        while (sale_q.size() == 0 && n < 50) begin
            tick();
            n++;
        end
        if (sale_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got 0 start pulses expected 1", name);
        end else begin
            s = sale_q.pop_front();
            check({name, "_cost"}, s[15:8], cost);
            check({name, "_volume"}, s[7:0], vol);
        end
    endtask

    initial begin
        reset_n = 1'b0; grade = 2'd0; nozzle_lift = 1'b0; flow_pulse = 1'b0; disp_done = 1'b0;
`ifdef FUEL_PREPAY_LIMIT_EN
        preset_limit = 8'd0;
`endif
        tick(); tick();
        check("rst_pump_on", pump_on, 0);
        check("rst_busy", busy, 0);
        check("rst_start", start, 0);
        check("rst_final_cost", final_cost, 0);
        check("rst_volume", volume, 0);
        reset_n = 1'b1;
        tick();

        // Grade 1, 5 pulses, grade changed mid-sale has no effect.
        lift(2'd1);
        check("s1_pump_after_lift", pump_on, 1);
        pulses(2);
        grade = 2'd2;
        pulses(3);
        drop();
        expect_sale("s1", 20, 5);
        done();

        // Grade 2, 25 pulses: stops at 95 with nozzle still up.
        lift(2'd2);
        pulses(25);
        check("s2_pump_off_at_limit", pump_on, 0);
        check("s2_busy_waiting", busy, 1);
        expect_sale("s2", 95, 19);
        drop();
        done();

        // Invalid grade ignored; re-lift with grade 0.
        lift(2'd3);
        tick();
        check("s3_busy_bad_grade", busy, 0);
        grade = 2'd0;
        drop();
        lift(2'd0);
        pulses(2);
        drop();
        expect_sale("s3", 6, 2);
        done();

        // Zero-pulse sale, lift during WAIT_DONE ignored, held nozzle never starts.
        lift(2'd1);
        drop();
        expect_sale("s4", 0, 0);
        lift(2'd1);
        tick();
        check("s4_lift_in_wait_pump", pump_on, 0);
        done();
        check("s4_held_nozzle_idle", busy, 0);
        drop();
        lift(2'd1);
        check("s4_relift_pump", pump_on, 1);
        drop();
        expect_sale("s4b", 0, 0);
        done();

        // Reset mid-sale: pump drops at once, no start.
        lift(2'd0);
        pulses(3);
        check("s5_volume_before_reset", volume, 3);
        #2 reset_n = 1'b0;
        #1;
        check("s5_pump_async", pump_on, 0);
        check("s5_busy_async", busy, 0);
        check("s5_final_async", final_cost, 0);
        check("s5_volume_async", volume, 0);
        tick();
        nozzle_lift = 1'b0;
        tick();
        reset_n = 1'b1;
        tick(); tick(); tick();
        check("s5_no_start", sale_q.size(), 0);

`ifdef FUEL_PREPAY_LIMIT_EN
        // Prepay of 12 at grade 0 stops after 4 pulses; zero preset means 99.
        preset_limit = 8'd12;
        lift(2'd0);
        pulses(8);
        expect_sale("p1", 12, 4);
        drop();
        done();
        preset_limit = 8'd0;
        lift(2'd2);
        pulses(25);
        expect_sale("p2", 95, 19);
        drop();
        done();
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
